// File: rtl/lane_rx_decoder.sv
// Multi-lane RX block decoder: captures one encoded block per lane and streams it out
// a byte per cycle, tracking block type, sync-header errors and deskew readiness.
module lane_rx_decoder #(
  parameter int NUM_LANES = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     enc_clk,
  input  logic                     rst,
  input  logic                     enable_dec,
  input  logic [1:0]               gen_speed,
  input  logic [3:0]               d_sel,
  input  logic [NUM_LANES*132-1:0] lanes_rx_enc,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  output logic [NUM_LANES*8-1:0]   lanes_rx,
  output logic                     byte_valid,
  output logic                     sob,
  output logic                     data_os,
  output logic                     enable_deskew,
  output logic [NUM_LANES-1:0]     hdr_err,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_BLK = 2'd1;
  localparam logic [1:0] ST_STREAM   = 2'd2;

  localparam logic [1:0] GEN4     = 2'b00;
  localparam logic [1:0] GEN3     = 2'b01;
  localparam logic [1:0] GEN2     = 2'b10;
  localparam logic [1:0] GEN_RSVD = 2'b11;

  logic [1:0]                 state_q, state_d;
  logic [3:0]                 idx_q, idx_d;
  logic [1:0]                 mode_q;
  logic                       blk_dos_q;
  logic                       first_blk_seen_q;
  logic [127:0]               blk_data_q [NUM_LANES];
  logic [NUM_LANES*8-1:0]     lanes_rx_q;
  logic                       byte_valid_q;
  logic                       sob_q;
  logic                       data_os_q;
  logic                       deskew_q;
  logic [NUM_LANES-1:0]       hdr_err_q;
  logic [ERR_CNT_W-1:0]       err_cnt_q;

  logic [3:0]                 last_idx;
  logic                       capture;
  logic                       emit;
  logic                       mode_is_gen4;
  logic [131:0]               field      [NUM_LANES];
  logic [127:0]               data_shift [NUM_LANES];
  logic [NUM_LANES-1:0]       hdr_bad;
  logic                       new_dos;
  logic [6:0]                 bit_off;
  logic [NUM_LANES*8-1:0]     cur_bytes;

  // Block length follows the mode latched at capture, not the live gen_speed.
  assign last_idx     = (mode_q == GEN2) ? 4'd7 : 4'd15;
  assign mode_is_gen4 = (mode_q == GEN4) || (mode_q == GEN_RSVD);
  assign blk_ready    = (state_q == ST_WAIT_BLK) ||
                        ((state_q == ST_STREAM) && (idx_q == last_idx));
  assign capture      = enable_dec && blk_valid && blk_ready;
  assign emit         = enable_dec && (state_q == ST_STREAM);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    new_dos = data_os_q;
    for (int n = 0; n < NUM_LANES; n++) begin
      field[n]      = lanes_rx_enc[n*132 +: 132];
      hdr_bad[n]    = 1'b0;
      data_shift[n] = field[n][127:0];
      case (gen_speed)
        GEN3: begin
          hdr_bad[n]    = (field[n][3:0] != 4'b0101) && (field[n][3:0] != 4'b1010);
          data_shift[n] = field[n][131:4];
        end
        GEN2: begin
          hdr_bad[n]    = (field[n][1:0] != 2'b01) && (field[n][1:0] != 2'b10);
          data_shift[n] = field[n][129:2];
        end
        default: ;
      endcase
    end
    // An illegal lane-0 header keeps the previous block type.
    case (gen_speed)
      GEN3: begin
        if (field[0][3:0] == 4'b1010)      new_dos = 1'b1;
        else if (field[0][3:0] == 4'b0101) new_dos = 1'b0;
      end
      GEN2: begin
        if (field[0][1:0] == 2'b10)      new_dos = 1'b1;
        else if (field[0][1:0] == 2'b01) new_dos = 1'b0;
      end
      default: new_dos = (d_sel == 4'd8);
    endcase
  end

  always_comb begin
    bit_off = {idx_q, 3'b000};
    for (int n = 0; n < NUM_LANES; n++) begin
      cur_bytes[n*8 +: 8] = blk_data_q[n][bit_off +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!enable_dec) begin
      state_d = ST_IDLE;
      idx_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gen_speed != GEN_RSVD) state_d = ST_WAIT_BLK;
        end
        ST_WAIT_BLK: begin
          if (blk_valid) begin
            state_d = ST_STREAM;
            idx_d   = 4'd0;
          end
        end
        ST_STREAM: begin
          if (idx_q == last_idx) begin
            idx_d   = 4'd0;
            state_d = blk_valid ? ST_STREAM : ST_WAIT_BLK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 4'd0;
        end
      endcase
    end
  end

  // NOTE: block payload registers carry no reset; they are only read after a capture has loaded them.
  always_ff @(posedge enc_clk) begin
    if (capture) begin
      for (int n = 0; n < NUM_LANES; n++) begin
        blk_data_q[n] <= data_shift[n];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      idx_q            <= 4'd0;
      mode_q           <= GEN4;
      blk_dos_q        <= 1'b0;
      first_blk_seen_q <= 1'b0;
      lanes_rx_q       <= '0;
      byte_valid_q     <= 1'b0;
      sob_q            <= 1'b0;
      data_os_q        <= 1'b0;
      deskew_q         <= 1'b0;
      hdr_err_q        <= '0;
      err_cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      byte_valid_q <= emit;
      sob_q        <= emit && (idx_q == 4'd0);
      hdr_err_q    <= capture ? hdr_bad : '0;

      if (capture) begin
        mode_q    <= gen_speed;
        blk_dos_q <= new_dos;
      end

      if (emit) lanes_rx_q <= cur_bytes;

      // Block type and deskew readiness change together with byte 0 of a block.
      if (emit && (idx_q == 4'd0)) begin
        data_os_q        <= blk_dos_q;
        first_blk_seen_q <= 1'b1;
        if (!mode_is_gen4 || first_blk_seen_q) deskew_q <= 1'b1;
      end

      if (state_d == ST_IDLE) begin
        err_cnt_q        <= '0;
        deskew_q         <= 1'b0;
        first_blk_seen_q <= 1'b0;
      end else if (capture && (|hdr_bad) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign lanes_rx      = lanes_rx_q;
  assign byte_valid    = byte_valid_q;
  assign sob           = sob_q;
  assign data_os       = data_os_q;
  assign enable_deskew = deskew_q;
  assign hdr_err       = hdr_err_q;
  assign err_cnt       = err_cnt_q;

endmodule
